lsu_rmw_ctrl: RTL
=================

Name: lsu_rmw_ctrl

Overview:
- Load/store initiator between the CPU datapath and the word-addressed data memory.
- The memory reads combinationally, writes synchronously on posedge when Mem_write is high, and ignores address bits [1:0].
- The block accepts byte, halfword and word load/store requests over a valid/ready handshake.
- It formats and sign- or zero-extends load data, and performs read-modify-write for sub-word stores.
- It flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 100, number of 32-bit words in the data memory. Word index req_addr[31:2] >= MEM_WORDS is out of range.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal and flagged as an error.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  formatted load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned, out of range, or illegal size.
- mem_addr  output  32  byte address to memory, {req_addr[31:2], 2'b00}.
- mem_wd  output  32  write data to memory.
- mem_rd  input  32  combinational read data from memory.
- mem_write  output  1  memory write enable.

Behaviour:
- FSM states: IDLE, ACCESS, WRITE, RESP.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_addr=0, mem_wd=0. All captured request registers are cleared.
- IDLE:
  - req_ready=1.
  - On req_valid, capture write, size, unsigned, addr and wdata.
  - Error check at capture: halfword with addr[0]=1, word with addr[1:0]!=0, size=11, or addr[31:2] >= MEM_WORDS.
  - On error: go to RESP with err=1. No memory cycle is issued.
  - Otherwise go to ACCESS.
- Outside IDLE, req_ready=0. req_valid is ignored; requests are never queued.
- ACCESS: mem_addr is driven from the captured address.
  - Load: select the lane of mem_rd. Byte lane = addr[1:0]; halfword lane = addr[1]. Extend the selected lane to 32 bits and register it into resp_rdata. Go to RESP.
  - Word store: mem_write=1, mem_wd=wdata. Go to RESP.
  - Sub-word store: mem_write=0. Register mem_rd into the merge register and replace the addressed byte or halfword lane with wdata[7:0] or wdata[15:0]. Go to WRITE.
- WRITE: mem_write=1, mem_wd=merged word, mem_addr unchanged. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_rdata and resp_err are held stable during it. Go to IDLE.
- The earliest next request is accepted in the IDLE cycle after RESP.
- Latency from the accept edge to resp_valid:
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- mem_write is combinational from state, gated with !rst. Asserting rst during ACCESS or WRITE suppresses the pending write at that edge, and the FSM returns to IDLE with no resp_valid.
- mem_write is never asserted in IDLE or RESP, or for any errored request.
- Store responses: resp_rdata=0.
- Boundaries:
  - The last valid word index is MEM_WORDS-1.
  - Byte address 4*MEM_WORDS and above is out of range.
  - Byte and halfword lane selection is little-endian (byte 0 = bits [7:0]).

Test Plan:
- mem[2]=0x8081_7F01. LB addr 0x0A gives resp_rdata=0xFFFF_FF81. LBU addr 0x0A gives 0x0000_0081. LH addr 0x08 gives 0x0000_7F01. resp_valid comes 2 cycles after each accept.
- mem[3]=0x1122_3344, SB addr 0x0D, wdata 0xAB. mem_write is asserted only in the WRITE cycle with mem_wd=0x1122_AB44. A following LW addr 0x0C returns 0x1122_AB44.
- SH addr 0x12, wdata 0xBEEF, old mem[4]=0. Memory ends as 0xBEEF_0000 with resp_err=0. SW addr 0x00, wdata 0xDEAD_BEEF writes mem[0] in the ACCESS cycle.
- LW addr 0x06, SH addr 0x03, and LB addr 400 (MEM_WORDS=100) each give resp_err=1 one cycle after accept, with mem_write never high. LB addr 396 succeeds.
- SB accepted, rst pulsed during the WRITE cycle: mem_write stays 0, memory is unchanged, no resp_valid, and req_ready=1 the next cycle.
- req_valid held high continuously: back-to-back requests are accepted only in IDLE cycles. req_ready drops during ACCESS, WRITE and RESP, and each request gets exactly one resp_valid pulse.

Source files
------------

// File: rtl/lsu_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_rmw_ctrl
// Description : Load/store initiator for a word-addressed data memory.
//               Byte/halfword/word loads with sign/zero extension, word
//               stores, and read-modify-write for sub-word stores.
//               Misaligned, out-of-range and illegal-size requests are
//               answered with an error and never touch memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_rmw_ctrl #(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        mem_write
);

  localparam logic [1:0]  c_size_byte = 2'b00;
  localparam logic [1:0]  c_size_half = 2'b01;
  localparam logic [1:0]  c_size_word = 2'b10;
  localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;

  logic        w_req_err;
  logic [4:0]  w_byte_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  // Request error classification, evaluated on the live request at capture
  always_comb begin
    w_req_err = 1'b0;
    if (req_size == 2'b11)                              w_req_err = 1'b1;
    if ((req_size == c_size_half) && req_addr[0])       w_req_err = 1'b1;
    if ((req_size == c_size_word) && (req_addr[1:0] != 2'b00)) w_req_err = 1'b1;
    if (req_addr[31:2] >= c_mem_words)                  w_req_err = 1'b1;
  end

  // Little-endian lane extraction/extension and sub-word merge from mem_rd
  always_comb begin
    w_byte_sh = {addr_q[1:0], 3'b000};
    w_byte    = mem_rd[w_byte_sh +: 8];
    w_half    = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_q)
      c_size_byte: w_load_ext = {{24{~uns_q & w_byte[7]}}, w_byte};
      c_size_half: w_load_ext = {{16{~uns_q & w_half[15]}}, w_half};
      default:     w_load_ext = mem_rd;
    endcase
    w_merged = mem_rd;
    if (size_q == c_size_byte) begin
      w_merged[w_byte_sh +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      w_merged[31:16] = wdata_q[15:0];
    end else begin
      w_merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d      = req_write;
          size_d       = req_size;
          uns_d        = req_unsigned;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          resp_rdata_d = 32'h0;
          resp_err_d   = w_req_err;
          req_ready_d  = 1'b0;
          if (w_req_err) begin
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            state_d      = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          resp_rdata_d = w_load_ext;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (size_q == c_size_word) begin
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          merge_d      = w_merged;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      default: begin
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  // State and captured-request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
    end
  end

  // Memory strobe is decoded from state so a reset in ACCESS/WRITE kills it
  always_comb begin
    mem_write = 1'b0;
    mem_wd    = 32'h0;
    if (state_q == WRITE) begin
      mem_write = ~rst;
      mem_wd    = merge_q;
    end else if ((state_q == ACCESS) && write_q && (size_q == c_size_word)) begin
      mem_write = ~rst;
      mem_wd    = wdata_q;
    end
  end

  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
`default_nettype wire
